// File: rtl/seq_det_arbiter_if.sv
// Bundles the serial requester and detector result signals shared between
// the requester side (master) and the round-robin sequence detector (slave).
interface seq_det_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [PAT_W-1:0]  pattern;
  logic              overlap_en;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] bit_in;
  logic [NUM_CH-1:0] gnt;
  logic              match;
  logic              done;
  logic [CH_W-1:0]   done_ch;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output pattern, overlap_en, req, bit_in,
    input  gnt, match, done, done_ch, match_cnt
  );

  modport slave (
    input  pattern, overlap_en, req, bit_in,
    output gnt, match, done, done_ch, match_cnt
  );
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin shared Mealy sequence detector: grant registered one cycle after IDLE sees req,
// FRAME_LEN bits streamed, result on a one-cycle done pulse; granted frames cannot be stalled.
module seq_det_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int PAT_W     = 4,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  seq_det_arbiter_if.slave  io_bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int K_W  = $clog2(FRAME_LEN);
  localparam int F_W  = $clog2(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_CH-1:0] r_gnt;
  logic [CH_W-1:0]   r_sel;
  logic [CH_W-1:0]   r_rr;
  logic [CH_W-1:0]   r_done_ch;
  logic [K_W-1:0]    r_k;
  logic [PAT_W-2:0]  r_hist;
  logic [F_W-1:0]    r_fill;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [PAT_W-1:0]  r_pat;
  logic              r_ovl;

  logic [CH_W-1:0]   w_pick;
  logic              w_pick_vld;
  logic              w_bit;
  logic [PAT_W-1:0]  w_win;
  logic              w_match;
  logic              w_last;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [F_W-1:0]    w_fill_inc;

  // Descending scan so the lowest offset from the rr pointer wins.
  always_comb begin
    logic [CH_W-1:0] idx;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    idx        = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(r_rr) + i) % NUM_CH);
      if (io_bus.req[idx]) begin
        w_pick     = idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_bit      = io_bus.bit_in[r_sel];
  assign w_win      = {r_hist, w_bit};
  assign w_match    = (r_state == S_STREAM) && (r_fill == F_W'(PAT_W - 1)) && (w_win == r_pat);
  assign w_last     = (r_k == K_W'(FRAME_LEN - 1));
  assign w_cnt_nxt  = (w_match && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
  assign w_fill_inc = (r_fill == F_W'(PAT_W - 1)) ? r_fill : r_fill + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_pick_vld) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last)     w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt       <= '0;
      r_sel       <= '0;
      r_rr        <= '0;
      r_done_ch   <= '0;
      r_k         <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_cnt       <= '0;
      r_match_cnt <= '0;
      r_pat       <= '0;
      r_ovl       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_sel  <= w_pick;
            r_gnt  <= NUM_CH'(1) << w_pick;
            r_pat  <= io_bus.pattern;
            r_ovl  <= io_bus.overlap_en;
            r_k    <= '0;
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
          end
        end
        S_STREAM: begin
          r_k    <= r_k + 1'b1;
          r_hist <= w_win[PAT_W-2:0];
          // Non-overlapping mode discards the history consumed by a match.
          r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
          r_cnt  <= w_cnt_nxt;
          if (w_last) begin
            r_gnt       <= '0;
            r_done_ch   <= r_sel;
            r_match_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          r_rr <= (r_sel == CH_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.gnt       = r_gnt;
  assign io_bus.match     = w_match;
  assign io_bus.done      = (r_state == S_DONE);
  assign io_bus.done_ch   = r_done_ch;
  assign io_bus.match_cnt = r_match_cnt;
endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed and randomized frames checked against a window-scanning reference model
// of the detector and a first-at-or-after-pointer model of the round-robin arbiter.
module tb_seq_det_arbiter;
  localparam int NC = 4;
  localparam int PW = 4;
  localparam int FL = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_arbiter_if #(.NUM_CH(NC), .PAT_W(PW), .CNT_W(CW)) bus ();

  seq_det_arbiter #(.NUM_CH(NC), .PAT_W(PW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int ptr      = 0;
  int last_ch  = 0;
  int last_cnt = 0;
  int grant_cyc = 0;
  int wait_n   = 0;
  int prev_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NC-1:0] r, input int p);
    for (int i = 0; i < NC; i++)
      if (r[(p + i) % NC]) return (p + i) % NC;
    return -1;
  endfunction

  // Scan every window ending at k; in non-overlap mode the next window must start after the match.
  function automatic logic [FL-1:0] model(input logic [FL-1:0] fb, input logic [PW-1:0] pat, input logic ov);
    logic [FL-1:0] m;
    logic [PW-1:0] win;
    int start;
    m = '0;
    start = 0;
    for (int k = 0; k < FL; k++) begin
      if (k - start >= PW - 1) begin
        for (int j = 0; j < PW; j++) win[PW-1-j] = fb[FL-1-(k-PW+1+j)];
        if (win == pat) begin
          m[k] = 1'b1;
          if (!ov) start = k + 1;
        end
      end
    end
    return m;
  endfunction

  task automatic frame(input string nm, input logic [NC-1:0] rq, input logic [FL-1:0] fb,
                       input logic [PW-1:0] pat, input logic ov, input logic [PW-1:0] pat_mid,
                       input logic [NC-1:0] rq_mid, input int abort_k);
    int ch;
    int n;
    logic [FL-1:0] m;
    ch = rr_pick(rq, ptr);
    m  = model(fb, pat, ov);
    n  = $countones(m);
    if (n > (1 << CW) - 1) n = (1 << CW) - 1;
    bus.req        = rq;
    bus.pattern    = pat;
    bus.overlap_en = ov;
    wait_n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      wait_n++;
      if (bus.gnt == '0) begin
        chk({nm, "/hold_done"}, bus.done, 0);
        chk({nm, "/hold_ch"}, bus.done_ch, last_ch);
        chk({nm, "/hold_cnt"}, bus.match_cnt, last_cnt);
      end
    end while (bus.gnt == '0 && wait_n < 4);
    grant_cyc = cyc;
    chk({nm, "/gnt"}, bus.gnt, 1 << ch);
    for (int k = 0; k < FL; k++) begin
      bus.bit_in = NC'($urandom);
      bus.bit_in[ch] = fb[FL-1-k];
      if (k == 2) bus.req = rq_mid;
      if (k == 5) begin
        bus.pattern    = pat_mid;
        bus.overlap_en = ~ov;
      end
      if (k == abort_k) begin
        rst = 1'b0;
        #1;
        chk({nm, "/abort_gnt"}, bus.gnt, 0);
        chk({nm, "/abort_match"}, bus.match, 0);
        chk({nm, "/abort_done"}, bus.done, 0);
        return;
      end
      #1;
      chk($sformatf("%s/match_k%0d", nm, k), bus.match, m[k]);
      chk($sformatf("%s/gnt_k%0d", nm, k), bus.gnt, 1 << ch);
      chk($sformatf("%s/done_k%0d", nm, k), bus.done, 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk({nm, "/done"}, bus.done, 1);
    chk({nm, "/done_gnt"}, bus.gnt, 0);
    chk({nm, "/done_ch"}, bus.done_ch, ch);
    chk({nm, "/match_cnt"}, bus.match_cnt, n);
    ptr      = (ch + 1) % NC;
    last_ch  = ch;
    last_cnt = n;
  endtask

  initial begin
    logic [NC-1:0] rq;
    logic [PW-1:0] pt;
    rst            = 1'b0;
    bus.req        = '1;
    bus.bit_in     = '0;
    bus.pattern    = 4'b1101;
    bus.overlap_en = 1'b0;

    repeat (3) begin
      @(negedge clk);
      bus.bit_in = NC'($urandom);
      #1;
      chk("rst/gnt", bus.gnt, 0);
      chk("rst/done", bus.done, 0);
      chk("rst/match", bus.match, 0);
      chk("rst/cnt", bus.match_cnt, 0);
      chk("rst/ch", bus.done_ch, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel/gnt", bus.gnt, 0);

    frame("t2", 4'b0001, 16'b1101_1101_0000_0000, 4'b1101, 1'b0, 4'b1101, 4'b0001, -1);
    chk("t1/grant_lat", wait_n, 1);

    frame("t3ov", 4'b0100, 16'b1101_1010_0000_0000, 4'b1101, 1'b1, 4'b1101, 4'b0100, -1);
    frame("t3no", 4'b0100, 16'b1101_1010_0000_0000, 4'b1101, 1'b0, 4'b1101, 4'b0100, -1);

    pt = PW'($urandom);
    frame("t4s", 4'b1111, FL'($urandom), pt, 1'b1, PW'($urandom), 4'b1111, -1);
    prev_cyc = grant_cyc;
    repeat (5) begin
      pt = PW'($urandom);
      frame("t4rr", 4'b1111, FL'($urandom), pt, 1'($urandom), PW'($urandom), 4'b1111, -1);
      chk("t4/period", grant_cyc - prev_cyc, 18);
      prev_cyc = grant_cyc;
    end
    repeat (3) begin
      pt = PW'($urandom);
      frame("t4sub", 4'b1010, FL'($urandom), pt, 1'($urandom), PW'($urandom), 4'b1010, -1);
    end

    frame("t5", 4'b0001, 16'b1001_1101_1001_0000, 4'b1001, 1'b0, 4'b1101, 4'b0000, -1);

    for (int r = 0; r < 20; r++) begin
      rq = NC'($urandom_range(1, (1 << NC) - 1));
      pt = PW'($urandom);
      frame("rnd", rq, FL'($urandom), pt, 1'($urandom), PW'($urandom), rq, -1);
    end

    frame("t6", 4'b0100, FL'($urandom), 4'b1101, 1'b1, 4'b1101, 4'b0100, 8);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t6/rst_done", bus.done, 0);
      chk("t6/rst_gnt", bus.gnt, 0);
    end
    @(negedge clk);
    rst      = 1'b1;
    ptr      = 0;
    last_ch  = 0;
    last_cnt = 0;
    frame("t6b", 4'b1111, 16'b1101_1011_0110_1101, 4'b1101, 1'b1, 4'b0000, 4'b1111, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
